// File: rtl/sensor_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the vehicle-sensor debounce stage: the per-channel
// FSM state encoding, register widths and the default timing constants.
// Optional build macro used by the design files: SENSOR_STUCK_DETECT_EN.
// ---------------------------------------------------------------------------
package sensor_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;
    localparam int STUCK_W = 16;

    localparam int DEFAULT_DEBOUNCE = 4;
    localparam int DEFAULT_STUCK    = 1000;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ON     = 2'd2,
        DISARM = 2'd3
    } state_t;

    // States in which the channel reports an accepted-high level.
    function automatic logic is_high(input state_t st);
        return (st == ON) || (st == DISARM);
    endfunction

endpackage

// File: rtl/sensor_debounce_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan
// One sensor channel: 2-flop synchroniser followed by a 4-state debounce FSM
// (IDLE/ARM/ON/DISARM). Optional stuck detection when the macro
// SENSOR_STUCK_DETECT_EN is defined.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw sensor line, asynchronous to clk
//   x      out  debounced level, registered
//   stuck  out  stuck flag (constant 0 unless SENSOR_STUCK_DETECT_EN)
// ---------------------------------------------------------------------------
module debounce_chan
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int STUCK_CYCLES    = DEFAULT_STUCK
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic x,
    output logic stuck
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             x_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // ARM/DISARM count consecutive samples of the new level; any sample of
    // the old level drops straight back, discarding the partial count.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sync_b) begin
                    state_nxt = ARM;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ARM: begin
                if (!sync_b) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ON: begin
                if (!sync_b) begin
                    state_nxt = DISARM;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DISARM: begin
                if (sync_b) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stuck_cnt;
    logic [STUCK_W-1:0] stuck_cnt_nxt;
    logic               stuck_nxt;

    // Counter saturates at STUCK_MAX so a long hold cannot wrap and re-arm.
    // The flag only clears once the FSM is back in IDLE.
    always_comb begin
        stuck_cnt_nxt = '0;
        stuck_nxt     = stuck;
        if (is_high(state)) begin
            stuck_cnt_nxt = (stuck_cnt < STUCK_MAX) ? stuck_cnt + STUCK_W'(1) : stuck_cnt;
            if (stuck_cnt_nxt >= STUCK_MAX) begin
                stuck_nxt = 1'b1;
            end
        end
        if (state_nxt == IDLE) begin
            stuck_nxt = 1'b0;
        end
        x_nxt = is_high(state_nxt) && !stuck_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else begin
            stuck_cnt <= stuck_cnt_nxt;
            stuck     <= stuck_nxt;
        end
    end
`else
    always_comb begin
        x_nxt = is_high(state_nxt);
    end

    assign stuck = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            x     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            x     <= x_nxt;
        end
    end

endmodule

// File: rtl/sensor_debounce.sv
// ---------------------------------------------------------------------------
// sensor_debounce
// Conditions the two raw vehicle-sensor lines into clean, synchronised,
// debounced levels for the traffic light controller, and emits a one-cycle
// strobe whenever either debounced level changes.
// Optional build macro: SENSOR_STUCK_DETECT_EN (per-channel stuck detection).
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   raw1   in   raw sensor, direction 1
//   raw2   in   raw sensor, direction 2
//   x1     out  debounced level, channel 1
//   x2     out  debounced level, channel 2
//   chg    out  one-cycle pulse the edge after {x1,x2} changed
//   stuck  out  per-channel stuck flags, bit0 = channel 1
// ---------------------------------------------------------------------------
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int STUCK_CYCLES    = DEFAULT_STUCK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw1,
    input  logic       raw2,
    output logic       x1,
    output logic       x2,
    output logic       chg,
    output logic [1:0] stuck
);

    logic [1:0] x_prev;

    debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan1 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw1),
        .x     (x1),
        .stuck (stuck[0])
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan2 (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw2),
        .x     (x2),
        .stuck (stuck[1])
    );

    // Comparing against the previous pair gives a single pulse even when
    // both channels change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev <= 2'b00;
            chg    <= 1'b0;
        end else begin
            x_prev <= {x1, x2};
            chg    <= ({x1, x2} != x_prev);
        end
    end

endmodule

// File: tb/tb_sensor_debounce.sv
// ---------------------------------------------------------------------------
// tb_sensor_debounce
// Self-checking bench for sensor_debounce: directed scenarios followed by
// randomized sensor activity, compared every cycle against a behavioural
// model (delayed samples + run-length acceptance rule).
// ---------------------------------------------------------------------------
module tb_sensor_debounce;

    localparam int D  = 4;
    localparam int SC = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw1;
    logic       raw2;
    logic       x1;
    logic       x2;
    logic       chg;
    logic [1:0] stuck;

    int checks  = 0;
    int errors  = 0;
    int chg_cnt = 0;

    always #5 clk = ~clk;

    sensor_debounce #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw1  (raw1),
        .raw2  (raw2),
        .x1    (x1),
        .x2    (x2),
        .chg   (chg),
        .stuck (stuck)
    );

    // Model state: per channel, raw delayed by two edges, accepted level,
    // length of the current run of samples disagreeing with it, hold time.
    bit m_d0  [2];
    bit m_d1  [2];
    bit m_acc [2];
    int m_run [2];
    int m_hi  [2];
    bit m_stk [2];
    bit m_out [2];
    bit m_prev[2];
    bit m_chg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_d0[c] = 0; m_d1[c] = 0; m_acc[c] = 0; m_run[c] = 0;
            m_hi[c] = 0; m_stk[c] = 0; m_out[c] = 0; m_prev[c] = 0;
        end
        m_chg = 0;
    endtask

    task automatic model_edge();
        bit s;
        bit acc_old;
        bit r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_chg = (m_out[0] != m_prev[0]) || (m_out[1] != m_prev[1]);
        for (int c = 0; c < 2; c++) begin
            m_prev[c] = m_out[c];
            r = (c == 0) ? raw1 : raw2;
            s = m_d1[c];
            m_d1[c] = m_d0[c];
            m_d0[c] = r;
            acc_old = m_acc[c];
            if (s != m_acc[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == D) begin
                m_acc[c] = ~m_acc[c];
                m_run[c] = 0;
            end
`ifdef SENSOR_STUCK_DETECT_EN
            if (acc_old) begin
                if (m_hi[c] < SC) m_hi[c]++;
                if (m_hi[c] >= SC) m_stk[c] = 1;
            end else begin
                m_hi[c] = 0;
            end
            if (!m_acc[c]) m_stk[c] = 0;
            m_out[c] = m_acc[c] && !m_stk[c];
`else
            if (acc_old) m_hi[c] = 0;
            m_out[c] = m_acc[c];
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (chg === 1'b1) chg_cnt++;
        chk("x1", 32'(x1), 32'(m_out[0]));
        chk("x2", 32'(x2), 32'(m_out[1]));
        chk("chg", 32'(chg), 32'(m_chg));
        chk("stuck", 32'(stuck), {30'd0, m_stk[1], m_stk[0]});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts edges until the selected output reaches lvl (0:x1 1:x2 2:stuck[0]).
    task automatic count_until(input int sel, input bit lvl, output int n);
        logic v;
        n = 0;
        do begin
            step();
            n++;
            v = (sel == 0) ? x1 : (sel == 1) ? x2 : stuck[0];
        end while (v !== lvl && n < 60);
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_x1", 32'(x1), 32'd0);
        chk("rst_x2", 32'(x2), 32'd0);
        chk("rst_chg", 32'(chg), 32'd0);
        chk("rst_stuck", 32'(stuck), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        raw1 = 1'b1;
        raw2 = 1'b1;
        rst_n = 1'b1;
        #1;
        reset_now();
        steps(5);
        rst_n = 1'b1;
        count_until(0, 1'b1, n);
        chk("release_lat", 32'(n), 32'd6);
        chk("release_x2", 32'(x2), 32'd1);
        steps(3);

        // Simultaneous clean fall: same latency, single strobe.
        chg_cnt = 0;
        raw1 = 1'b0; raw2 = 1'b0;
        count_until(0, 1'b0, n);
        chk("fall_lat", 32'(n), 32'd6);
        steps(4);
        chk("fall_chg_pulses", 32'(chg_cnt), 32'd1);

        // Channel 1 alone rising then falling.
        chg_cnt = 0;
        raw1 = 1'b1;
        count_until(0, 1'b1, n);
        chk("rise1_lat", 32'(n), 32'd6);
        steps(3);
        raw1 = 1'b0;
        count_until(0, 1'b0, n);
        chk("fall1_lat", 32'(n), 32'd6);
        steps(3);
        chk("ch1_chg_pulses", 32'(chg_cnt), 32'd2);

        // Glitch shorter than D samples is rejected.
        chg_cnt = 0;
        raw2 = 1'b1;
        steps(3);
        raw2 = 1'b0;
        steps(10);
        chk("glitch_x2", 32'(x2), 32'd0);
        chk("glitch_chg", 32'(chg_cnt), 32'd0);

        // Exactly D samples is accepted.
        raw2 = 1'b1;
        steps(4);
        raw2 = 1'b0;
        count_until(1, 1'b1, n);
        chk("pulse4_lat", 32'(n), 32'd2);
        steps(12);

        // Simultaneous rise.
        chg_cnt = 0;
        raw1 = 1'b1; raw2 = 1'b1;
        count_until(0, 1'b1, n);
        chk("sim_lat", 32'(n), 32'd6);
        chk("sim_x2", 32'(x2), 32'd1);
        steps(3);
        chk("sim_chg_pulses", 32'(chg_cnt), 32'd1);
        raw1 = 1'b0; raw2 = 1'b0;
        steps(12);

        // Reset in the middle of ARM discards the partial count.
        raw1 = 1'b1;
        steps(4);
        reset_now();
        steps(3);
        rst_n = 1'b1;
        count_until(0, 1'b1, n);
        chk("rearm_lat", 32'(n), 32'd6);
        raw1 = 1'b0;
        steps(12);

`ifdef SENSOR_STUCK_DETECT_EN
        chg_cnt = 0;
        raw1 = 1'b1;
        count_until(0, 1'b1, n);
        chk("stk_rise_lat", 32'(n), 32'd6);
        count_until(0, 1'b0, n);
        chk("stk_force_lat", 32'(n), 32'(SC));
        chk("stk_flag", 32'(stuck[0]), 32'd1);
        step();
        chk("stk_chg_pulses", 32'(chg_cnt), 32'd2);
        raw1 = 1'b0;
        count_until(2, 1'b0, n);
        chk("stk_clear_lat", 32'(n), 32'd6);
        steps(5);
`endif

        // Random activity with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) raw1 = ~raw1;
            if ($urandom_range(0, 5) == 0) raw2 = ~raw2;
            if ($urandom_range(0, 599) == 0) begin
                reset_now();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_debounce.md
Name: sensor_debounce

Overview:
Upstream conditioning stage for the traffic light controller FSM. Takes the two raw, asynchronous vehicle-sensor lines and delivers clean, synchronised, debounced levels x1/x2 straight to the controller's x1/x2 inputs. Each channel runs a 2-flop synchroniser plus a 4-state debounce FSM. Also emits a one-cycle change strobe for downstream logging/timing.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised samples needed to accept a level change; legal range 2..255
STUCK_CYCLES, 1000, cycles a channel may stay accepted-high before it is declared stuck (used only with SENSOR_STUCK_DETECT_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
raw1  in  1  raw sensor, direction 1 (asynchronous to clk)
raw2  in  1  raw sensor, direction 2 (asynchronous to clk)
x1  out  1  debounced level for channel 1, registered
x2  out  1  debounced level for channel 2, registered
chg  out  1  one-cycle pulse when {x1,x2} changed on the previous edge
stuck  out  2  per-channel stuck flag, bit0 = ch1; constant 0 without macro

Behaviour:
- Reset (rst_n low, async): sync flops 0, FSM IDLE, counters 0, x1=x2=0, chg=0, stuck=0. Release is synchronous to next rising edge; reset mid-debounce discards partial count.
- Sync: s = raw through 2 flops; s valid 2 edges after raw changes.
- FSM per channel, count register cnt (8 bits):
  IDLE (x=0): s=1 -> ARM, cnt<=1; else stay.
  ARM (x=0): s=0 -> IDLE, cnt<=0; cnt==DEBOUNCE_CYCLES-1 -> ON, cnt<=0; else cnt++.
  ON (x=1): s=0 -> DISARM, cnt<=1; else stay.
  DISARM (x=1): s=1 -> ON, cnt<=0; cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0; else cnt++.
- x = (state==ON or DISARM), registered with state.
- Latency: clean raw step -> x follows on the (DEBOUNCE_CYCLES+2)th rising edge after the raw change; identical for rise and fall.
- Any glitch shorter than DEBOUNCE_CYCLES samples aborts ARM/DISARM; x never toggles.
- Channels fully independent; simultaneous changes on both legal, both follow same latency.
- chg: registered, chg<=({x1,x2} != previous {x1,x2}); one cycle wide, asserts the edge after x changes; simultaneous x1/x2 change gives a single pulse.

Optional Feature:
SENSOR_STUCK_DETECT_EN
- Defined: per-channel 16-bit stuck counter increments every cycle in ON/DISARM, cleared in IDLE/ARM. Reaching STUCK_CYCLES sets stuck[i], forces x_i=0 (chg fires on that drop). stuck[i] is sticky until the channel FSM returns to IDLE (clean debounced release) or reset; x_i then follows normal FSM again.
- Undefined: no stuck counters; stuck tied 2'b00; x driven by FSM only.

Decomposition:
- Package sensor_pkg: FSM state encodings (IDLE=0, ARM=1, ON=2, DISARM=3), state width 2, counter width 8, default debounce/stuck constants.
- Sub-module debounce_chan (sync + FSM + optional stuck counter, one channel), instantiated twice; top adds chg logic.

Test Plan:
- Reset: hold rst_n=0 with raw1=raw2=1 -> x1=x2=0, chg=0, stuck=0 throughout; release -> x1 rises exactly 6 edges later (D=4).
- Clean step: raw1 0->1 at edge 0 -> x1=1 after edge 6, chg=1 for edge 7 only; raw1 1->0 -> x1=0 after 6 edges, one chg pulse.
- Glitch: raw2 high 3 cycles then low (D=4) -> x2 stays 0, chg never asserts; 4-cycle pulse -> x2 rises.
- Simultaneous: raw1 and raw2 rise same cycle -> x1,x2 rise same edge, single chg pulse.
- Async reset mid-ARM (after 2 samples) -> x=0 immediately, new debounce restarts from 0 after release.
- With SENSOR_STUCK_DETECT_EN, STUCK_CYCLES=20: raw1 held high -> x1=1 then forced 0 after 20 cycles, stuck[0]=1, chg pulse; raw1 low 6 cycles -> stuck[0] clears.
